bcd_mux_display: RTL and testbench

- Multi-digit, time-multiplexed 7-segment display driver. Parametrised successor to the single-digit BCD-to-7-segment decoder.
- Captures a packed BCD/hex word and scans one digit per slot.
- Supports lamp test, global blank, ripple (leading-zero) blanking across digits, decimal points, a hex/BCD mode and common-cathode/anode polarity.
- Sits between the datapath's number registers and the board's segment/digit pins.

---
 rtl/bcd_mux_display_pkg.sv | 42 ++++
 rtl/seg7_glyph_decode.sv | 39 +++
 rtl/bcd_mux_display.sv | 134 +++++++++++++
 tb/tb_bcd_mux_display.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_mux_display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Glyphs are active-high, bit order gfedcba (bit 0 = segment a).
package bcd_mux_display_pkg;

  localparam int SEG_W  = 7;
  localparam int CODE_W = 4;

  // Segment bit positions inside a glyph
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [SEG_W-1:0] GLYPH_0    = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1    = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2    = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3    = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4    = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5    = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6    = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7    = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8    = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9    = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A    = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B    = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C    = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D    = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E    = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F    = 7'h71;
  localparam logic [SEG_W-1:0] GLYPH_DASH = 7'h40;
  localparam logic [SEG_W-1:0] GLYPH_OFF  = 7'h00;
  localparam logic [SEG_W-1:0] GLYPH_ALL  = 7'h7F;

  // Bits needed to count 0..n-1; never less than one bit
  function automatic int unsigned cnt_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 4-bit code to 7-segment glyph decoder.
//   code_i     : digit code 0..15
//   hex_mode_i : 1 = show A b C d E F for 10..15, 0 = show dash
//   glyph_o    : active-high segments, gfedcba
module seg7_glyph_decode
  import bcd_mux_display_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              hex_mode_i,
  output logic [SEG_W-1:0]  glyph_o
);

  logic [SEG_W-1:0] hex_glyph;

  always_comb begin
    hex_glyph = GLYPH_DASH;
    case (code_i)
      4'h0: hex_glyph = GLYPH_0;
      4'h1: hex_glyph = GLYPH_1;
      4'h2: hex_glyph = GLYPH_2;
      4'h3: hex_glyph = GLYPH_3;
      4'h4: hex_glyph = GLYPH_4;
      4'h5: hex_glyph = GLYPH_5;
      4'h6: hex_glyph = GLYPH_6;
      4'h7: hex_glyph = GLYPH_7;
      4'h8: hex_glyph = GLYPH_8;
      4'h9: hex_glyph = GLYPH_9;
      4'hA: hex_glyph = GLYPH_A;
      4'hB: hex_glyph = GLYPH_B;
      4'hC: hex_glyph = GLYPH_C;
      4'hD: hex_glyph = GLYPH_D;
      4'hE: hex_glyph = GLYPH_E;
      default: hex_glyph = GLYPH_F;
    endcase
  end

  assign glyph_o = (!hex_mode_i && code_i > 4'd9) ? GLYPH_DASH : hex_glyph;

endmodule

// File: rtl/bcd_mux_display.sv
// Time-multiplexed multi-digit 7-segment driver.
//   CLK, RST_N  : clock, async active-low reset
//   VALUE, DP   : packed digit codes / decimal points, captured on LOAD
//   LAMP_TEST   : all segments + DP on (highest priority)
//   BLANK       : all segments off, scanning continues
//   RBI         : enable leading-zero blanking
//   SEG, SEG_DP : segment drive for the digit in the current slot
//   DIGIT_EN    : one-hot digit enable, off during the first cycle of a slot
//   FRAME_DONE  : one-cycle pulse after each full scan frame
// All outputs are registered and show the (cnt, idx) of the previous cycle.
module bcd_mux_display
  import bcd_mux_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int COMMON_ANODE = 0,
  parameter int HEX_MODE     = 0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [CODE_W*NUM_DIGITS-1:0] VALUE,
  input  logic [NUM_DIGITS-1:0]        DP,
  input  logic                         LOAD,
  input  logic                         LAMP_TEST,
  input  logic                         RBI,
  input  logic                         BLANK,
  output logic [SEG_W-1:0]             SEG,
  output logic                         SEG_DP,
  output logic [NUM_DIGITS-1:0]        DIGIT_EN,
  output logic                         FRAME_DONE
);

  localparam int IW = cnt_width(NUM_DIGITS);
  localparam int CW = cnt_width(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic          INV      = (COMMON_ANODE != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DIGITS-1:0][CODE_W-1:0] sh_val_q, act_val_q;
  logic [NUM_DIGITS-1:0]             sh_dp_q, act_dp_q;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fd_q;

  logic                  slot_end, wrap;
  logic [NUM_DIGITS-1:0] rb;
  logic                  zero_run;
  logic [CODE_W-1:0]     cur_code;
  logic [SEG_W-1:0]      glyph;

  assign slot_end = (cnt_q == CNT_LAST);
  assign wrap     = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Leading-zero blanking walks down from the MSD; the run stops at the
  // first nonzero code or set DP. Digit 0 always stays lit.
  always_comb begin
    rb       = '0;
    zero_run = RBI;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (act_val_q[i] == '0) && !act_dp_q[i];
      rb[i]    = zero_run;
    end
  end

  assign cur_code = act_val_q[idx_q];

  seg7_glyph_decode u_glyph (
    .code_i     (cur_code),
    .hex_mode_i (HEX_MODE != 0),
    .glyph_o    (glyph)
  );

  always_comb begin
    if (LAMP_TEST) begin
      seg_d    = GLYPH_ALL;
      seg_dp_d = 1'b1;
    end else if (BLANK || rb[idx_q]) begin
      seg_d    = GLYPH_OFF;
      seg_dp_d = 1'b0;
    end else begin
      seg_d    = glyph;
      seg_dp_d = act_dp_q[idx_q];
    end
    // first cycle of each slot is dead time against ghosting
    en_d = '0;
    if (cnt_q != '0) en_d[idx_q] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      seg_q     <= {SEG_W{INV}};
      seg_dp_q  <= INV;
      en_q      <= {NUM_DIGITS{INV}};
      fd_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (LOAD) begin
        sh_val_q <= VALUE;
        sh_dp_q  <= DP;
      end
      // frame-aligned copy; a LOAD on this edge lands in the next frame
      if (wrap) begin
        act_val_q <= sh_val_q;
        act_dp_q  <= sh_dp_q;
      end
      seg_q    <= seg_d ^ {SEG_W{INV}};
      seg_dp_q <= seg_dp_d ^ INV;
      en_q     <= en_d ^ {NUM_DIGITS{INV}};
      fd_q     <= wrap;
    end
  end

  assign SEG        = seg_q;
  assign SEG_DP     = seg_dp_q;
  assign DIGIT_EN   = en_q;
  assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_bcd_mux_display.sv
module tb_bcd_mux_display;
  localparam int N  = 4;
  localparam int P  = 4;
  localparam int FR = N * P;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [15:0] VALUE = '0;
  logic [3:0]  DP = '0;
  logic LOAD = 1'b0, LAMP = 1'b0, RBI = 1'b0, BLANK = 1'b0;

  logic [6:0] seg0, seg1, seg2;
  logic dp0, dp1, dp2, fd0, fd1, fd2;
  logic [3:0] en0, en1, en2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  bcd_mux_display #(.NUM_DIGITS(N), .PRESCALE(P), .COMMON_ANODE(0), .HEX_MODE(0)) u0 (
    .CLK(CLK), .RST_N(RST_N), .VALUE(VALUE), .DP(DP), .LOAD(LOAD), .LAMP_TEST(LAMP),
    .RBI(RBI), .BLANK(BLANK), .SEG(seg0), .SEG_DP(dp0), .DIGIT_EN(en0), .FRAME_DONE(fd0));
  bcd_mux_display #(.NUM_DIGITS(N), .PRESCALE(P), .COMMON_ANODE(0), .HEX_MODE(1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .VALUE(VALUE), .DP(DP), .LOAD(LOAD), .LAMP_TEST(LAMP),
    .RBI(RBI), .BLANK(BLANK), .SEG(seg1), .SEG_DP(dp1), .DIGIT_EN(en1), .FRAME_DONE(fd1));
  bcd_mux_display #(.NUM_DIGITS(N), .PRESCALE(P), .COMMON_ANODE(1), .HEX_MODE(0)) u2 (
    .CLK(CLK), .RST_N(RST_N), .VALUE(VALUE), .DP(DP), .LOAD(LOAD), .LAMP_TEST(LAMP),
    .RBI(RBI), .BLANK(BLANK), .SEG(seg2), .SEG_DP(dp2), .DIGIT_EN(en2), .FRAME_DONE(fd2));

  // ---------------- reference model ----------------
  logic [6:0] GL [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int t = 0;                          // clock edges since reset release
  logic [15:0] sh_v = '0, act_v = '0;
  logic [3:0]  sh_dp = '0, act_dp = '0;
  logic [7:0]  exp_b = '0, exp_h = '0; // {dp, seg}, active-high, hex off / on
  logic [3:0]  exp_en = '0;
  logic        exp_fd = 1'b0;

  function automatic logic [7:0] view(bit hex, int d, bit lamp, bit blank, bit rbi,
                                      logic [15:0] v, logic [3:0] dpv);
    int code;
    code = int'((v >> (4 * d)) & 16'hF);
    if (lamp) return 8'hFF;
    if (blank) return 8'h00;
    if (rbi && d > 0 && (v >> (4 * d)) == 16'h0 && (dpv >> d) == 4'h0) return 8'h00;
    return {dpv[d], (code > 9 && !hex) ? 7'h40 : GL[code]};
  endfunction

  initial forever begin
    int c, d;
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      t = 0; sh_v = '0; act_v = '0; sh_dp = '0; act_dp = '0;
      exp_b = '0; exp_h = '0; exp_en = '0; exp_fd = 1'b0;
    end else begin
      c = t % P;
      d = (t / P) % N;
      exp_b  = view(1'b0, d, LAMP, BLANK, RBI, act_v, act_dp);
      exp_h  = view(1'b1, d, LAMP, BLANK, RBI, act_v, act_dp);
      exp_en = (c == 0) ? 4'h0 : 4'(1 << d);
      exp_fd = (t % FR == FR - 1);
      if (t % FR == FR - 1) begin act_v = sh_v; act_dp = sh_dp; end
      if (LOAD) begin sh_v = VALUE; sh_dp = DP; end
      t++;
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison of all three instances against the model
  initial forever begin
    logic [6:0] ns;
    logic [3:0] ne;
    @(negedge CLK);
    ns = ~exp_b[6:0];
    ne = ~exp_en;
    chk("seg0", {1'b0, seg0}, {1'b0, exp_b[6:0]});
    chk("dp0", {7'h0, dp0}, {7'h0, exp_b[7]});
    chk("en0", {4'h0, en0}, {4'h0, exp_en});
    chk("fd0", {7'h0, fd0}, {7'h0, exp_fd});
    chk("seg1", {1'b0, seg1}, {1'b0, exp_h[6:0]});
    chk("dp1", {7'h0, dp1}, {7'h0, exp_h[7]});
    chk("fd1", {7'h0, fd1}, {7'h0, exp_fd});
    chk("seg2", {1'b0, seg2}, {1'b0, ns});
    chk("dp2", {7'h0, dp2}, {7'h0, ~exp_b[7]});
    chk("en2", {4'h0, en2}, {4'h0, ne});
    chk("fd2", {7'h0, fd2}, {7'h0, exp_fd});
  end

  // ---------------- directed helpers ----------------
  task automatic wait_fd(string nm);
    bit hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge CLK);
      if (fd0) hit = 1'b1;
    end
    if (!hit) chk({nm, "_fd_timeout"}, 8'h0, 8'h1);
  endtask

  task automatic see_digit(int d, logic [6:0] e0, logic [6:0] e1, logic edp, string nm);
    bit hit = 1'b0;
    logic [3:0] oh, noh;
    logic [6:0] ne0;
    oh  = 4'(1 << d);
    noh = ~oh;
    ne0 = ~e0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge CLK);
      if (en0 == oh) hit = 1'b1;
    end
    if (!hit) chk({nm, "_timeout"}, 8'h0, 8'h1);
    else begin
      chk(nm, {1'b0, seg0}, {1'b0, e0});
      chk({nm, "_hex"}, {1'b0, seg1}, {1'b0, e1});
      chk({nm, "_dp"}, {7'h0, dp0}, {7'h0, edp});
      chk({nm, "_ca_seg"}, {1'b0, seg2}, {1'b0, ne0});
      chk({nm, "_ca_en"}, {4'h0, en2}, {4'h0, noh});
    end
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d);
    if (t % FR == FR - 1) @(negedge CLK);
    VALUE = v; DP = d; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    bit hit;
    repeat (3) @(negedge CLK);
    chk("rst_seg0", {1'b0, seg0}, 8'h00);
    chk("rst_en0", {4'h0, en0}, 8'h00);
    chk("rst_fd0", {7'h0, fd0}, 8'h00);
    chk("rst_seg_ca", {1'b0, seg2}, 8'h7F);
    chk("rst_en_ca", {4'h0, en2}, 8'h0F);
    chk("rst_dp_ca", {7'h0, dp2}, 8'h01);
    #2 RST_N = 1'b1;

    // 1: dead cycle then digit 0 for three cycles, dead, digit 1
    @(negedge CLK); chk("idle_dead", {4'h0, en0}, 8'h00);
    @(negedge CLK); chk("idle_d0", {4'h0, en0}, 8'h01);
    repeat (4) @(negedge CLK); chk("idle_d1", {4'h0, en0}, 8'h02);
    wait_fd("idle");
    k = 0;
    do begin @(negedge CLK); k++; end while (!fd0 && k < 40);
    chk("fd_period", 8'(k), 8'd16);

    // 2: load 0x1234 mid-frame
    do_load(16'h1234, 4'h0);
    wait_fd("ld1234");
    see_digit(0, 7'h66, 7'h66, 1'b0, "v1234_d0");
    see_digit(1, 7'h4F, 7'h4F, 1'b0, "v1234_d1");
    see_digit(2, 7'h5B, 7'h5B, 1'b0, "v1234_d2");
    see_digit(3, 7'h06, 7'h06, 1'b0, "v1234_d3");

    // 3: ripple blanking, then a DP stopping the run
    RBI = 1'b1;
    do_load(16'h0070, 4'h0);
    wait_fd("ld0070");
    see_digit(0, 7'h3F, 7'h3F, 1'b0, "rb_d0");
    see_digit(1, 7'h07, 7'h07, 1'b0, "rb_d1");
    see_digit(2, 7'h00, 7'h00, 1'b0, "rb_d2");
    see_digit(3, 7'h00, 7'h00, 1'b0, "rb_d3");
    do_load(16'h0070, 4'b0100);
    wait_fd("ld0070dp");
    see_digit(2, 7'h3F, 7'h3F, 1'b1, "rbdp_d2");
    see_digit(3, 7'h00, 7'h00, 1'b0, "rbdp_d3");

    // 4: invalid codes, hex mode, priority
    RBI = 1'b0;
    do_load(16'h00AF, 4'h0);
    wait_fd("ld00af");
    see_digit(0, 7'h40, 7'h71, 1'b0, "hx_d0");
    see_digit(1, 7'h40, 7'h77, 1'b0, "hx_d1");
    see_digit(2, 7'h3F, 7'h3F, 1'b0, "hx_d2");
    LAMP = 1'b1; BLANK = 1'b1;
    see_digit(0, 7'h7F, 7'h7F, 1'b1, "lamp_d0");
    see_digit(3, 7'h7F, 7'h7F, 1'b1, "lamp_d3");
    LAMP = 1'b0;
    see_digit(1, 7'h00, 7'h00, 1'b0, "blank_d1");
    BLANK = 1'b0;

    // 5: all-eights, checked on the common-anode instance inside see_digit
    do_load(16'h8888, 4'h0);
    wait_fd("ld8888");
    see_digit(0, 7'h7F, 7'h7F, 1'b0, "ca_d0");
    see_digit(2, 7'h7F, 7'h7F, 1'b0, "ca_d2");

    // 6a: LOAD on the wrap edge shows only after the next FRAME_DONE
    hit = 1'b0;
    for (int j = 0; j < 40 && !hit; j++) begin
      @(negedge CLK);
      if (t % FR == FR - 1) hit = 1'b1;
    end
    if (!hit) chk("wrap_timeout", 8'h0, 8'h1);
    VALUE = 16'h5555; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    chk("wrap_fd", {7'h0, fd0}, 8'h01);
    see_digit(0, 7'h7F, 7'h7F, 1'b0, "wrap_old");
    wait_fd("wrap_next");
    see_digit(0, 7'h6D, 7'h6D, 1'b0, "wrap_new");

    // 6b: asynchronous reset at cnt=2, idx=2
    hit = 1'b0;
    for (int j = 0; j < 40 && !hit; j++) begin
      @(negedge CLK);
      if (t % P == 2 && (t / P) % N == 2) hit = 1'b1;
    end
    if (!hit) chk("arst_timeout", 8'h0, 8'h1);
    #1 RST_N = 1'b0;
    #1;
    chk("arst_seg0", {1'b0, seg0}, 8'h00);
    chk("arst_en0", {4'h0, en0}, 8'h00);
    chk("arst_dp0", {7'h0, dp0}, 8'h00);
    chk("arst_seg_ca", {1'b0, seg2}, 8'h7F);
    chk("arst_en_ca", {4'h0, en2}, 8'h0F);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    see_digit(0, 7'h3F, 7'h3F, 1'b0, "post_rst_d0");
    repeat (20) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
